frame_demux: RTL and testbench
==============================

FRAME_DEMUX -- requirements
Module: frame_demux

Interface
REQ-001 The block SHALL use a single clock domain; reset is synchronous and active-high; all state changes SHALL occur on the rising edge of clk.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 din  input  1  serial time-multiplexed data bit, one slot per accepted cycle.
REQ-005 din_valid  input  1  din carries a valid slot bit this cycle; low means stall.
REQ-006 sync  input  1  qualified by din_valid; marks din as slot 0 of a new frame.
REQ-007 q0, q1, q2, q3  output  1 each  registered slot outputs of the last committed frame.
REQ-008 frame_valid  output  1  one-cycle pulse: q0..q3 (and parity_err) were just updated.
REQ-009 slot  output  2  index of the next slot to be written; 0 when idle.
REQ-010 busy  output  1  high while a frame is partially captured (state != IDLE).
REQ-011 parity_err  output  1  parity mismatch flag of the last committed frame; valid with frame_valid.

Function
REQ-012 The FSM SHALL have states IDLE, CAPTURE, and PARITY (PARITY exists only with the macro, see REQ-027).
REQ-013 In IDLE, din_valid=1 with sync=1 SHALL store din into shadow bit 0, set slot=1, and go to CAPTURE; din_valid=1 with sync=0 SHALL be ignored.
REQ-014 In CAPTURE, din_valid=1 with sync=0 SHALL store din into shadow[slot] and increment slot.
REQ-015 Stall: din_valid=0 SHALL hold state, slot, and shadow unchanged, in any state.
REQ-016 Frame end without the macro: on the edge accepting slot 3, shadow bits 0..2 plus din SHALL commit to q0..q3, frame_valid SHALL be 1 for the next cycle, and the state SHALL return to IDLE with slot=0.
REQ-017 Latency: q0..q3 and frame_valid SHALL update on the same edge that accepts the final bit of the frame (slot 3, or the parity bit with the macro).
REQ-018 Resync: din_valid=1 with sync=1 in CAPTURE or PARITY SHALL abandon the partial frame without committing, store din as the new slot 0, set slot=1, and stay in or enter CAPTURE.
REQ-019 Back-to-back frames: a sync accepted in the cycle frame_valid is high SHALL start a new frame with no lost cycle.
REQ-020 q0..q3 SHALL hold their last committed values until the next commit; abandoned frames SHALL never alter them.
REQ-021 frame_valid SHALL never be high in two consecutive cycles.
REQ-022 slot SHALL wrap only via commit or resync; it SHALL never advance past 3.

Reset
REQ-023 On reset=1 at a clock edge, the state SHALL become IDLE.
REQ-024 On reset=1 at a clock edge, slot, shadow, q0..q3, frame_valid, busy, and parity_err SHALL all become 0.
REQ-025 Reset SHALL take priority over din_valid and sync in the same cycle.
REQ-026 A reset mid-frame SHALL discard the frame; no frame_valid SHALL follow it.

Configuration
REQ-027 Macro FRAME_DEMUX_PARITY_EN defined: accepting slot 3 in CAPTURE SHALL go to PARITY instead of committing.
REQ-028 In PARITY, din_valid=1 with sync=0 SHALL commit the frame as in REQ-016.
REQ-029 On that commit, parity_err SHALL be set to q0^q1^q2^q3^din, using even parity (0 = parity correct).
REQ-030 Macro FRAME_DEMUX_PARITY_EN undefined: the PARITY state SHALL not exist, a frame SHALL be 4 accepted bits, and parity_err SHALL be constant 0.

Verification
REQ-031 Reset, then slots 1,0,1,1 (sync on first, din_valid=1 each cycle) -> one cycle later q3..q0=1101, frame_valid pulses exactly once, busy=0, slot=0.
REQ-032 Same frame with din_valid=0 inserted between every bit -> identical q values; frame_valid only after the 4th accepted bit; slot holds during stalls.
REQ-033 Send 2 bits 1,1 then sync with bits 0,1,0,0 -> q3..q0=0010; exactly one frame_valid; earlier q values unchanged until that commit.
REQ-034 Two frames 1010 then 0101 sent back-to-back, the second sync in the frame_valid cycle -> two frame_valid pulses 4 cycles apart, q3..q0=0101 at the end.
REQ-035 reset=1 asserted after 2 bits of a frame -> all outputs 0 next cycle, no frame_valid; a following full frame 1111 commits normally.
REQ-036 With FRAME_DEMUX_PARITY_EN defined: frame 1,1,0,0 with parity 0 -> parity_err=0; the same frame with parity 1 -> parity_err=1; frame_valid pulses 5 accepted bits after sync in both cases.

Source files
------------

// File: rtl/frame_demux.sv
// ============================================================================
// Module      : frame_demux
// Description : Serial 4-slot frame demultiplexer with sync-based alignment,
//               stall support and optional even-parity slot
//               (enable with `define FRAME_DEMUX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_demux (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic       q0,
  output logic       q1,
  output logic       q2,
  output logic       q3,
  output logic       frame_valid,
  output logic [1:0] slot,
  output logic       busy,
  output logic       parity_err
);

`ifdef FRAME_DEMUX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    PARITY  = 2'd2
  } state_t;
  localparam int c_SHADOW_W = 4;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1
  } state_t;
  localparam int c_SHADOW_W = 3;
`endif

  state_t                r_state;
  logic [1:0]            r_slot;
  logic [c_SHADOW_W-1:0] r_shadow;
  logic [3:0]            r_q;
  logic                  r_frame_valid;
`ifdef FRAME_DEMUX_PARITY_EN
  logic                  r_parity_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_slot        <= 2'd0;
      r_shadow      <= '0;
      r_q           <= 4'd0;
      r_frame_valid <= 1'b0;
`ifdef FRAME_DEMUX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      if (din_valid) begin
        if (sync) begin
          // A sync always (re)starts a frame, abandoning any partial capture.
          r_shadow[0] <= din;
          r_slot      <= 2'd1;
          r_state     <= CAPTURE;
        end else begin
          case (r_state)
            IDLE: begin
            end
            CAPTURE: begin
              if (r_slot == 2'd3) begin
`ifdef FRAME_DEMUX_PARITY_EN
                r_shadow[3] <= din;
                r_state     <= PARITY;
`else
                r_q           <= {din, r_shadow[2:0]};
                r_frame_valid <= 1'b1;
                r_slot        <= 2'd0;
                r_state       <= IDLE;
`endif
              end else begin
                case (r_slot)
                  2'd1:    r_shadow[1] <= din;
                  2'd2:    r_shadow[2] <= din;
                  default: r_shadow[0] <= din;
                endcase
                r_slot <= r_slot + 2'd1;
              end
            end
`ifdef FRAME_DEMUX_PARITY_EN
            PARITY: begin
              // Here din is the parity bit; even parity over data plus parity.
              r_q           <= r_shadow;
              r_parity_err  <= ^{r_shadow, din};
              r_frame_valid <= 1'b1;
              r_slot        <= 2'd0;
              r_state       <= IDLE;
            end
`endif
            default: begin
              r_slot  <= 2'd0;
              r_state <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign q0          = r_q[0];
  assign q1          = r_q[1];
  assign q2          = r_q[2];
  assign q3          = r_q[3];
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign busy        = (r_state != IDLE);
`ifdef FRAME_DEMUX_PARITY_EN
  assign parity_err  = r_parity_err;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_demux.sv
// ============================================================================
// Module      : tb_frame_demux
// Description : Directed self-checking bench for frame_demux (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_demux;

  logic       clk;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic       q0, q1, q2, q3;
  logic       frame_valid;
  logic [1:0] slot;
  logic       busy;
  logic       parity_err;

  int r_checks;
  int r_errors;
  int r_fv_count;

  frame_demux u_dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .q0          (q0),
    .q1          (q1),
    .q2          (q2),
    .q3          (q3),
    .frame_valid (frame_valid),
    .slot        (slot),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses last one full cycle, so sampling on the falling edge counts each once.
  always @(negedge clk) if (frame_valid === 1'b1) r_fv_count++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rs, input logic dv, input logic sy, input logic d);
    @(negedge clk);
    reset     = rs;
    din_valid = dv;
    sync      = sy;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] qv();
    return {4'd0, q3, q2, q1, q0};
  endfunction

  logic [3:0] v_bits;

  initial begin
    r_checks   = 0;
    r_errors   = 0;
    r_fv_count = 0;
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    check("rst_q",     qv(),              8'h0);
    check("rst_fv",    {7'd0, frame_valid}, 8'h0);
    check("rst_busy",  {7'd0, busy},      8'h0);
    check("rst_slot",  {6'd0, slot},      8'h0);
    check("rst_par",   {7'd0, parity_err}, 8'h0);

    // Non-sync data in IDLE is ignored.
    step(0, 1, 0, 1);
    check("idle_ign_busy", {7'd0, busy}, 8'h0);
    check("idle_ign_slot", {6'd0, slot}, 8'h0);

    // Basic frame, slots 1,0,1,1 -> q3..q0 = 1101.
    r_fv_count = 0;
    step(0, 1, 1, 1);
    check("f1_busy", {7'd0, busy}, 8'h1);
    check("f1_slot1", {6'd0, slot}, 8'h1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    check("f1_slot3", {6'd0, slot}, 8'h3);
    check("f1_q_hold", qv(), 8'h0);
    step(0, 1, 0, 1);
    check("f1_q", qv(), 8'hD);
    check("f1_fv", {7'd0, frame_valid}, 8'h1);
    check("f1_busy_end", {7'd0, busy}, 8'h0);
    check("f1_slot_end", {6'd0, slot}, 8'h0);
    step(0, 0, 0, 0);
    check("f1_fv_drop", {7'd0, frame_valid}, 8'h0);
    check("f1_fv_cnt", r_fv_count[7:0], 8'd1);

    // Same frame with a stall after every bit.
    r_fv_count = 0;
    v_bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, (i == 0), v_bits[i]);
      if (i < 3) begin
        step(0, 0, 1, ~v_bits[i]);
        check($sformatf("stall_slot%0d", i), {6'd0, slot}, 8'(i + 1));
        check($sformatf("stall_fv%0d", i), {7'd0, frame_valid}, 8'h0);
      end
    end
    check("stall_q", qv(), 8'hD);
    check("stall_fv", {7'd0, frame_valid}, 8'h1);
    step(0, 0, 0, 0);
    check("stall_fv_cnt", r_fv_count[7:0], 8'd1);

    // Resync: two bits then a fresh frame 0,1,0,0 -> q3..q0 = 0010.
    r_fv_count = 0;
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    check("resync_slot", {6'd0, slot}, 8'h1);
    check("resync_q_hold", qv(), 8'hD);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    check("resync_fv_early", {7'd0, frame_valid}, 8'h0);
    step(0, 1, 0, 0);
    check("resync_q", qv(), 8'h2);
    step(0, 0, 0, 0);
    check("resync_fv_cnt", r_fv_count[7:0], 8'd1);

    // Back-to-back: q3..q0 = 1010 then 0101, second sync in the pulse cycle.
    r_fv_count = 0;
    v_bits = 4'b1010;
    for (int i = 0; i < 4; i++) step(0, 1, (i == 0), v_bits[i]);
    check("b2b_q1", qv(), 8'hA);
    check("b2b_fv1", {7'd0, frame_valid}, 8'h1);
    v_bits = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, (i == 0), v_bits[i]);
      if (i == 0) begin
        check("b2b_fv_gap", {7'd0, frame_valid}, 8'h0);
        check("b2b_slot", {6'd0, slot}, 8'h1);
      end
    end
    check("b2b_q2", qv(), 8'h5);
    check("b2b_fv2", {7'd0, frame_valid}, 8'h1);
    step(0, 0, 0, 0);
    check("b2b_fv_cnt", r_fv_count[7:0], 8'd2);

    // Reset mid-frame, with valid data present to test reset priority.
    r_fv_count = 0;
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(1, 1, 0, 1);
    check("mid_rst_q", qv(), 8'h0);
    check("mid_rst_busy", {7'd0, busy}, 8'h0);
    check("mid_rst_slot", {6'd0, slot}, 8'h0);
    check("mid_rst_fv", {7'd0, frame_valid}, 8'h0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    check("mid_rst_no_fv", r_fv_count[7:0], 8'd0);
    check("mid_rst_idle", {7'd0, busy}, 8'h0);
    for (int i = 0; i < 4; i++) step(0, 1, (i == 0), 1'b1);
    check("post_rst_q", qv(), 8'hF);
    check("post_rst_fv", {7'd0, frame_valid}, 8'h1);
    check("post_rst_par", {7'd0, parity_err}, 8'h0);
    step(0, 0, 0, 0);
    check("post_rst_fv_cnt", r_fv_count[7:0], 8'd1);

    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule

`default_nettype wire
